// File: rtl/ipg_pkg.sv
// Shared constants and helpers for the inter-frame-gap transmit arbiter.
// Covers 64b/66b sync headers, block type codes, the fixed idle/error blocks and terminate detection.
package ipg_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] BLOCK_TYPE_IDLE  = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_START = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_T0    = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_T1    = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_T2    = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_T3    = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_T4    = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_T5    = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_T6    = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_T7    = 8'hff;

  localparam logic [63:0] IDLE_BLOCK = {56'h0, BLOCK_TYPE_IDLE};
  localparam logic [63:0] ERR_BLOCK  = 64'h3C78_F1E3_C78F_1E1E;

  typedef enum logic [0:0] {
    ST_GAP   = 1'b0,
    ST_FRAME = 1'b1
  } tx_state_e;

  function automatic logic is_term(input logic [1:0] hdr, input logic [7:0] btype);
    logic hit;
    case (btype)
      BLOCK_TYPE_T0, BLOCK_TYPE_T1, BLOCK_TYPE_T2, BLOCK_TYPE_T3,
      BLOCK_TYPE_T4, BLOCK_TYPE_T5, BLOCK_TYPE_T6, BLOCK_TYPE_T7: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return (hdr == SYNC_CTRL) && hit;
  endfunction

endpackage

// File: rtl/ipg_sync_fifo.sv
// First-word-fall-through synchronous FIFO with free-space count and sticky overflow flag.
// A write to a full FIFO is accepted only when a read frees a slot in the same cycle.
module ipg_sync_fifo #(
  parameter int W  = 66,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [AW:0]   space,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] store_r [DEPTH];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic [AW:0]  count_s;
  logic         full_s;
  logic         do_wr_s;
  logic         do_rd_s;
  logic         ovf_r;

  assign count_s = wptr_r - rptr_r;
  assign empty   = (count_s == (AW+1)'(0));
  assign full_s  = (count_s == (AW+1)'(DEPTH));
  assign do_rd_s = rd && !empty;
  assign do_wr_s = wr && (!full_s || do_rd_s);
  assign rdata   = store_r[rptr_r[AW-1:0]];
  assign space   = (AW+1)'(DEPTH) - count_s;
  assign ovf     = ovf_r;

  // storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      store_r[wptr_r[AW-1:0]] <= wdata;
    end
  end

  // pointers carry one extra bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r <= (AW+1)'(0);
      rptr_r <= (AW+1)'(0);
      ovf_r  <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end
      if (do_rd_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
      ovf_r <= ovf_r | (wr && !do_wr_s);
    end
  end

endmodule

// File: rtl/ipg_tx_arb.sv
// Transmit arbiter: streams 64b/66b network frames and slips memory reply chunks into
// inter-frame gaps, one registered 66-bit block per cycle toward the PHY gearbox.
module ipg_tx_arb
  import ipg_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int HDR_W    = 2,
  parameter int NET_AW   = 3,
  parameter int MEM_AW   = 3,
  parameter int MEM_CH   = 2,
  parameter int MIN_GAP  = 1,
  parameter int MAX_GAP  = 4,
  parameter int PAUSE_TH = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         net_wr,
  input  logic [DATA_W-1:0]            net_wdata,
  input  logic [HDR_W-1:0]             net_whdr,
  input  logic [MEM_CH-1:0]            mem_wr,
  input  logic [MEM_CH*DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]            tx_data,
  output logic [HDR_W-1:0]             tx_hdr,
  output logic                         ipg_en,
  output logic                         netfin,
  output logic                         pause,
  output logic [NET_AW:0]              net_space,
  output logic [MEM_CH*(MEM_AW+1)-1:0] mem_space,
  output logic                         net_ovf,
  output logic [MEM_CH-1:0]            mem_ovf,
  output logic                         net_udf
);

  localparam int NW        = DATA_W + HDR_W;
  localparam int GW        = $clog2(MAX_GAP + 1);
  localparam int CW        = (MEM_CH > 1) ? $clog2(MEM_CH) : 1;
  localparam int NET_DEPTH = 1 << NET_AW;

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;

  logic [NW-1:0]     net_head_s;
  logic              net_empty_s;
  logic [NET_AW:0]   net_space_s;
  logic              net_rd_s;
  logic              head_term_s;

  logic [DATA_W-1:0] mem_head_s [MEM_CH];
  logic [MEM_CH-1:0] mem_empty_s;
  logic [MEM_CH-1:0] mem_rd_s;

  tx_state_e         state_r, state_nxt_s;
  logic [GW-1:0]     gap_cnt_r, gap_nxt_s, gap_inc_s;
  logic [CW-1:0]     rr_r, rr_nxt_s;
  logic [CW-1:0]     sel_ch_s, idx_s;
  logic              sel_vld_s;
  logic              frame_ok_s;

  logic [DATA_W-1:0] data_nxt_s, tx_data_r;
  logic [HDR_W-1:0]  hdr_nxt_s, tx_hdr_r;
  logic              ipg_nxt_s, ipg_en_r;
  logic              fin_nxt_s, netfin_r;
  logic              udf_set_s, net_udf_r;
  logic              pause_nxt_s, pause_r;
  int                occ_nxt_s;

  // async assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  ipg_sync_fifo #(.W(NW), .AW(NET_AW)) u_net_fifo (
    .clk     (clk),
    .reset_n (rst_n_s),
    .wr      (net_wr),
    .wdata   ({net_whdr, net_wdata}),
    .rd      (net_rd_s),
    .rdata   (net_head_s),
    .empty   (net_empty_s),
    .space   (net_space_s),
    .ovf     (net_ovf)
  );

  for (genvar g = 0; g < MEM_CH; g++) begin : g_mem
    ipg_sync_fifo #(.W(DATA_W), .AW(MEM_AW)) u_mem_fifo (
      .clk     (clk),
      .reset_n (rst_n_s),
      .wr      (mem_wr[g]),
      .wdata   (mem_wdata[g*DATA_W +: DATA_W]),
      .rd      (mem_rd_s[g]),
      .rdata   (mem_head_s[g]),
      .empty   (mem_empty_s[g]),
      .space   (mem_space[g*(MEM_AW+1) +: (MEM_AW+1)]),
      .ovf     (mem_ovf[g])
    );
  end

  assign net_space   = net_space_s;
  assign head_term_s = is_term(2'(net_head_s[NW-1:DATA_W]), net_head_s[7:0]);
  assign gap_inc_s   = (int'(gap_cnt_r) >= MAX_GAP) ? gap_cnt_r : gap_cnt_r + GW'(1);
  assign frame_ok_s  = !net_empty_s && (int'(gap_cnt_r) >= MIN_GAP) &&
                       ((&mem_empty_s) || (int'(gap_cnt_r) >= MAX_GAP));

  // round-robin pick: first non-empty memory channel at or after rr
  always_comb begin
    sel_vld_s = 1'b0;
    sel_ch_s  = rr_r;
    idx_s     = rr_r;
    for (int i = 0; i < MEM_CH; i++) begin
      idx_s = CW'((int'(rr_r) + i) % MEM_CH);
      if (!sel_vld_s && !mem_empty_s[idx_s]) begin
        sel_vld_s = 1'b1;
        sel_ch_s  = idx_s;
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
  end

  // gap/frame arbitration: next state and next output block
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_cnt_r;
    rr_nxt_s    = rr_r;
    net_rd_s    = 1'b0;
    mem_rd_s    = {MEM_CH{1'b0}};
    data_nxt_s  = DATA_W'(IDLE_BLOCK);
    hdr_nxt_s   = HDR_W'(SYNC_CTRL);
    ipg_nxt_s   = 1'b0;
    fin_nxt_s   = 1'b0;
    udf_set_s   = 1'b0;
    case (state_r)
      ST_GAP: begin
        if (frame_ok_s) begin
          net_rd_s   = 1'b1;
          data_nxt_s = net_head_s[DATA_W-1:0];
          hdr_nxt_s  = net_head_s[NW-1:DATA_W];
          if (head_term_s) begin
            fin_nxt_s = 1'b1;
            gap_nxt_s = GW'(0);
          end else begin
            state_nxt_s = ST_FRAME;
          end
        end else if (sel_vld_s) begin
          mem_rd_s[sel_ch_s] = 1'b1;
          data_nxt_s = mem_head_s[sel_ch_s];
          hdr_nxt_s  = HDR_W'(SYNC_DATA);
          ipg_nxt_s  = 1'b1;
          rr_nxt_s   = CW'((int'(sel_ch_s) + 1) % MEM_CH);
          gap_nxt_s  = gap_inc_s;
        end else begin
          gap_nxt_s = gap_inc_s;
        end
      end
      ST_FRAME: begin
        if (net_empty_s) begin
          // underrun: close the frame with an error block
          data_nxt_s  = DATA_W'(ERR_BLOCK);
          udf_set_s   = 1'b1;
          gap_nxt_s   = GW'(0);
          state_nxt_s = ST_GAP;
        end else begin
          net_rd_s   = 1'b1;
          data_nxt_s = net_head_s[DATA_W-1:0];
          hdr_nxt_s  = net_head_s[NW-1:DATA_W];
          if (head_term_s) begin
            fin_nxt_s   = 1'b1;
            gap_nxt_s   = GW'(0);
            state_nxt_s = ST_GAP;
          end else begin
            state_nxt_s = ST_FRAME;
          end
        end
      end
      default: begin
        state_nxt_s = ST_GAP;
        gap_nxt_s   = GW'(MAX_GAP);
      end
    endcase
  end

  // net FIFO occupancy after this cycle's push/pop drives pause
  always_comb begin
    occ_nxt_s = NET_DEPTH - int'(net_space_s);
    if (net_wr && ((net_space_s != (NET_AW+1)'(0)) || net_rd_s)) begin
      occ_nxt_s = occ_nxt_s + 1;
    end else begin
      occ_nxt_s = occ_nxt_s;
    end
    if (net_rd_s) begin
      occ_nxt_s = occ_nxt_s - 1;
    end else begin
      occ_nxt_s = occ_nxt_s;
    end
    pause_nxt_s = (occ_nxt_s >= PAUSE_TH);
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r   <= ST_GAP;
      gap_cnt_r <= GW'(MAX_GAP);
      rr_r      <= CW'(0);
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_nxt_s;
      rr_r      <= rr_nxt_s;
    end
  end

  // registered transmit outputs and status flags
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_data_r <= DATA_W'(IDLE_BLOCK);
      tx_hdr_r  <= HDR_W'(SYNC_CTRL);
      ipg_en_r  <= 1'b0;
      netfin_r  <= 1'b0;
      pause_r   <= 1'b0;
      net_udf_r <= 1'b0;
    end else begin
      tx_data_r <= data_nxt_s;
      tx_hdr_r  <= hdr_nxt_s;
      ipg_en_r  <= ipg_nxt_s;
      netfin_r  <= fin_nxt_s;
      pause_r   <= pause_nxt_s;
      net_udf_r <= net_udf_r | udf_set_s;
    end
  end

  assign tx_data = tx_data_r;
  assign tx_hdr  = tx_hdr_r;
  assign ipg_en  = ipg_en_r;
  assign netfin  = netfin_r;
  assign pause   = pause_r;
  assign net_udf = net_udf_r;

endmodule

// File: tb/tb_ipg_tx_arb.sv
// Scoreboard bench for ipg_tx_arb: directed frames and memory chunks, expected blocks queued
// at stimulus time and popped by an independent monitor whenever a non-idle block appears.
module tb_ipg_tx_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         net_wr;
  logic [63:0]  net_wdata;
  logic [1:0]   net_whdr;
  logic [1:0]   mem_wr;
  logic [127:0] mem_wdata;
  logic [63:0]  tx_data;
  logic [1:0]   tx_hdr;
  logic         ipg_en, netfin, pause, net_ovf, net_udf;
  logic [3:0]   net_space;
  logic [7:0]   mem_space;
  logic [1:0]   mem_ovf;

  // second instance that never starts a frame, so its net FIFO only fills
  logic         h_net_wr;
  logic [63:0]  h_net_wdata;
  logic [63:0]  h_tx_data;
  logic [1:0]   h_tx_hdr;
  logic         h_ipg_en, h_netfin, h_pause, h_net_ovf, h_net_udf;
  logic [3:0]   h_net_space;
  logic [7:0]   h_mem_space;
  logic [1:0]   h_mem_ovf;

  always #5 clk = ~clk;

  ipg_tx_arb u_dut (
    .clk(clk), .reset_n(reset_n), .net_wr(net_wr), .net_wdata(net_wdata), .net_whdr(net_whdr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .tx_data(tx_data), .tx_hdr(tx_hdr), .ipg_en(ipg_en),
    .netfin(netfin), .pause(pause), .net_space(net_space), .mem_space(mem_space),
    .net_ovf(net_ovf), .mem_ovf(mem_ovf), .net_udf(net_udf)
  );

  ipg_tx_arb #(.MIN_GAP(5)) u_hold (
    .clk(clk), .reset_n(reset_n), .net_wr(h_net_wr), .net_wdata(h_net_wdata), .net_whdr(2'b01),
    .mem_wr(2'b00), .mem_wdata(128'h0), .tx_data(h_tx_data), .tx_hdr(h_tx_hdr), .ipg_en(h_ipg_en),
    .netfin(h_netfin), .pause(h_pause), .net_space(h_net_space), .mem_space(h_mem_space),
    .net_ovf(h_net_ovf), .mem_ovf(h_mem_ovf), .net_udf(h_net_udf)
  );

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        ipg;
    logic        fin;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  localparam logic [63:0] IDLE = 64'h1e;
  localparam logic [63:0] ERR  = 64'h3C78F1E3C78F1E1E;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] h, input logic [63:0] d, input logic ipg, input logic fin);
    exp_t e;
    e = '{hdr: h, data: d, ipg: ipg, fin: fin};
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic nw, input logic [1:0] nh, input logic [63:0] nd,
                     input logic [1:0] mw, input logic [127:0] md);
    net_wr = nw; net_whdr = nh; net_wdata = nd; mem_wr = mw; mem_wdata = md;
    @(posedge clk); #1;
    net_wr = 1'b0; mem_wr = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'b00, 64'h0, 2'b00, 128'h0);
  endtask

  // monitor: every non-idle output block must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && mon_en) begin
      if (!(tx_hdr == 2'b01 && tx_data == IDLE && !ipg_en && !netfin)) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", 128'({tx_hdr, tx_data, ipg_en, netfin}), 128'({2'b01, IDLE, 1'b0, 1'b0}));
        end else begin
          e = exp_q.pop_front();
          check("sb_blk", 128'({tx_hdr, tx_data, ipg_en, netfin}), 128'(e));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; net_wr = 1'b0; net_wdata = 64'h0; net_whdr = 2'b00;
    mem_wr = 2'b00; mem_wdata = 128'h0; h_net_wr = 1'b0; h_net_wdata = 64'h0;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_hdr", 128'(tx_hdr), 128'(2'b01));
    check("rst_data", 128'(tx_data), 128'(IDLE));
    check("rst_space", 128'(net_space), 128'(4'd8));
    check("rst_mspace", 128'(mem_space), 128'(8'h88));
    check("rst_flags", 128'({pause, ipg_en, netfin, net_ovf, mem_ovf, net_udf}), 128'(7'd0));
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst_idle", 128'({tx_hdr, tx_data}), 128'({2'b01, IDLE}));
    end
    mon_en = 1'b1;

    // simple frame, no memory traffic
    push(2'b01, 64'hD555555555555578, 1'b0, 1'b0);
    push(2'b10, 64'h1122334455667700, 1'b0, 1'b0);
    push(2'b01, 64'h0000000000000099, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 64'hD555555555555578, 2'b00, 128'h0);
    cyc(1'b1, 2'b10, 64'h1122334455667700, 2'b00, 128'h0);
    check("f1_start_cyc1", 128'(tx_data), 128'(64'hD555555555555578));
    cyc(1'b1, 2'b01, 64'h0000000000000099, 2'b00, 128'h0);
    check("f1_data_cyc2", 128'(tx_data), 128'(64'h1122334455667700));
    idle(1);
    check("f1_term_cyc3", 128'({tx_data, netfin, ipg_en}), 128'({64'h99, 1'b1, 1'b0}));
    idle(6);

    // chunks queued during a frame drain in the gap before the next frame
    push(2'b01, 64'hD5555555555555_78, 1'b0, 1'b0);
    push(2'b01, 64'h00000000000000aa, 1'b0, 1'b1);
    push(2'b10, 64'h1111111111111111, 1'b1, 1'b0);
    push(2'b10, 64'h2222222222222222, 1'b1, 1'b0);
    push(2'b10, 64'h3333333333333333, 1'b1, 1'b0);
    push(2'b01, 64'hAAAAAAAAAAAAAA78, 1'b0, 1'b0);
    push(2'b01, 64'h00000000000000b4, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 64'hD555555555555578, 2'b00, 128'h0);
    cyc(1'b1, 2'b01, 64'h00000000000000aa, 2'b11, {64'h2222222222222222, 64'h1111111111111111});
    cyc(1'b1, 2'b01, 64'hAAAAAAAAAAAAAA78, 2'b10, {64'h3333333333333333, 64'h0});
    cyc(1'b1, 2'b01, 64'h00000000000000b4, 2'b00, 128'h0);
    idle(10);

    // six chunks pending vs a waiting frame: four chunks, the frame, then the rest
    push(2'b01, 64'hBBBBBBBBBBBBBB78, 1'b0, 1'b0);
    push(2'b10, 64'h0102030405060708, 1'b0, 1'b0);
    push(2'b01, 64'h0000000000000087, 1'b0, 1'b1);
    push(2'b10, 64'hA000000000000000, 1'b1, 1'b0);
    push(2'b10, 64'hA000000000000001, 1'b1, 1'b0);
    push(2'b10, 64'hA000000000000002, 1'b1, 1'b0);
    push(2'b10, 64'hA000000000000003, 1'b1, 1'b0);
    push(2'b01, 64'hCCCCCCCCCCCCCC78, 1'b0, 1'b0);
    push(2'b01, 64'h00000000000000ff, 1'b0, 1'b1);
    push(2'b10, 64'hA000000000000004, 1'b1, 1'b0);
    push(2'b10, 64'hA000000000000005, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 64'hBBBBBBBBBBBBBB78, 2'b11, {64'hA000000000000001, 64'hA000000000000000});
    cyc(1'b1, 2'b10, 64'h0102030405060708, 2'b11, {64'hA000000000000003, 64'hA000000000000002});
    cyc(1'b1, 2'b01, 64'h0000000000000087, 2'b11, {64'hA000000000000005, 64'hA000000000000004});
    cyc(1'b1, 2'b01, 64'hCCCCCCCCCCCCCC78, 2'b00, 128'h0);
    cyc(1'b1, 2'b01, 64'h00000000000000ff, 2'b00, 128'h0);
    idle(12);

    // underrun: frame start with nothing behind it
    check("udf_clear", 128'(net_udf), 128'(1'b0));
    push(2'b01, 64'hDDDDDDDDDDDDDD78, 1'b0, 1'b0);
    push(2'b01, ERR, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 64'hDDDDDDDDDDDDDD78, 2'b00, 128'h0);
    idle(2);
    check("udf_err_blk", 128'({tx_hdr, tx_data}), 128'({2'b01, ERR}));
    check("udf_flag", 128'(net_udf), 128'(1'b1));
    idle(1);
    check("udf_back_gap", 128'({tx_hdr, tx_data, ipg_en}), 128'({2'b01, IDLE, 1'b0}));
    idle(4);

    // drain check: every queued expectation consumed within a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("sb_drain", 128'(exp_q.size()), 128'(0));

    // fill the held net FIFO: pause from the 6th write, 9th dropped
    for (int k = 1; k <= 9; k++) begin
      h_net_wr = 1'b1; h_net_wdata = 64'(k);
      @(posedge clk); #1;
      check("pause_k", 128'(h_pause), 128'(k >= 6));
      check("space_k", 128'(h_net_space), 128'((k >= 8) ? 0 : 8 - k));
      check("ovf_k", 128'(h_net_ovf), 128'(k == 9));
    end
    h_net_wr = 1'b0;
    check("hold_idle", 128'({h_tx_hdr, h_tx_data}), 128'({2'b01, IDLE}));

    // reset clears flags and FIFOs asynchronously
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst2_hold", 128'({h_pause, h_net_ovf, h_net_space}), 128'({1'b0, 1'b0, 4'd8}));
    check("rst2_dut", 128'({net_udf, net_ovf, tx_hdr, tx_data}), 128'({1'b0, 1'b0, 2'b01, IDLE}));
    #10 reset_n = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
